simd_alu_pipe: RTL and testbench

- Pipelined, parametrised SIMD integer ALU for the vector datapath; VLEN-bit operands split into 16-bit elements, grouped into 16/32/64/128-bit lanes by a per-operation lane mode.
- Operations: ADD, SUB, MUL, AND, OR, XOR, SLT. Per-element flags are returned.
- Valid/ready on input and output; fixed latency keeps results in order. Sits between vector register-file read and writeback.

---
 rtl/simd_alu_pkg.sv | 38 +++
 rtl/simd_lane_adder.sv | 43 ++++
 rtl/simd_alu_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_simd_alu_pipe.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_alu_pkg.sv
// Shared encodings and the lane-boundary helper for the SIMD ALU datapath.
// Combinational helpers only; no clocked state.
package simd_alu_pkg;

    localparam int ELEM_W    = 16;
    localparam int MAX_ELEMS = 64;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_MUL = 3'b010,
        OP_AND = 3'b011,
        OP_OR  = 3'b100,
        OP_SLT = 3'b101,
        OP_XOR = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        MODE_16  = 2'b00,
        MODE_32  = 2'b01,
        MODE_64  = 2'b10,
        MODE_128 = 2'b11
    } mode_e;

    // Bit e set when element e is the most-significant element of its lane (carry is cut there).
    function automatic logic [MAX_ELEMS-1:0] lane_cut_mask(input mode_e mode);
        logic [MAX_ELEMS-1:0] mask;
        int                   epl;
        epl  = 1 << mode;
        mask = '0;
        for (int e = 0; e < MAX_ELEMS; e++) begin
            mask[e] = ((e + 1) % epl) == 0;
        end
        return mask;
    endfunction

endpackage

// File: rtl/simd_lane_adder.sv
// Lane-segmented VLEN-bit adder/subtractor: carry ripples between 16-bit elements, cut at lane tops.
// Purely combinational; per-element carry-out and signed-overflow are reported for every element.
module simd_lane_adder
    import simd_alu_pkg::*;
#(
    parameter  int VLEN = 256,
    localparam int NE   = VLEN / ELEM_W
) (
    input  logic [VLEN-1:0] a_i,
    input  logic [VLEN-1:0] b_i,
    input  logic [NE-1:0]   cut_i,
    input  logic            sub_i,
    output logic [VLEN-1:0] sum_o,
    output logic [NE-1:0]   cout_o,
    output logic [NE-1:0]   ovf_o
);

    always_comb begin
        logic              c;
        logic [ELEM_W-1:0] ea;
        logic [ELEM_W-1:0] eb;
        logic [ELEM_W:0]   s;

        sum_o  = '0;
        cout_o = '0;
        ovf_o  = '0;
        c      = sub_i;
        ea     = '0;
        eb     = '0;
        s      = '0;
        for (int e = 0; e < NE; e++) begin
            ea = a_i[e*ELEM_W +: ELEM_W];
            eb = b_i[e*ELEM_W +: ELEM_W] ^ {ELEM_W{sub_i}};
            s  = {1'b0, ea} + {1'b0, eb} + {{ELEM_W{1'b0}}, c};
            sum_o[e*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
            cout_o[e] = s[ELEM_W];
            ovf_o[e]  = (ea[ELEM_W-1] == eb[ELEM_W-1]) && (s[ELEM_W-1] != ea[ELEM_W-1]);
            // A new lane starts above a cut element: re-inject the subtract carry-in.
            c = cut_i[e] ? sub_i : s[ELEM_W];
        end
    end

endmodule

// File: rtl/simd_alu_pipe.sv
// SIMD ALU (ADD/SUB/MUL/AND/OR/XOR/SLT, 16..128-bit lanes), LAT-cycle fixed latency, in_ready = !out_valid || out_ready.
// Macro SIMD_ALU_SAT_EN builds signed saturation for ADD/SUB; compute is ahead of the stage chain so synthesis can retime it.
module simd_alu_pipe
    import simd_alu_pkg::*;
#(
    parameter  int VLEN    = 256,
    parameter  int LAT     = 2,
    parameter  int TAG_W   = 4,
    localparam int NLANE16 = VLEN / ELEM_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic [1:0]         in_mode,
    input  logic               in_sat,
    input  logic [VLEN-1:0]    in_a,
    input  logic [VLEN-1:0]    in_b,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VLEN-1:0]    out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic [NLANE16-1:0] out_carry,
    output logic [NLANE16-1:0] out_ovf,
    output logic [NLANE16-1:0] out_zero,
    output logic [NLANE16-1:0] out_neg,
    output logic               out_err
);

    typedef struct packed {
        logic [VLEN-1:0]    dat;
        logic [TAG_W-1:0]   tag;
        logic [NLANE16-1:0] carry;
        logic [NLANE16-1:0] ovf;
        logic [NLANE16-1:0] zero;
        logic [NLANE16-1:0] neg;
        logic               err;
    } res_t;

    op_e                op;
    mode_e              mode;
    logic               addsub;
    logic               sub_en;
    logic [NLANE16-1:0] lane_cut;
    logic [NLANE16-1:0] cut;
    logic [NLANE16-1:0] lsb;
    logic [NLANE16-1:0] add_cout;
    logic [NLANE16-1:0] add_ovf;
    logic [VLEN-1:0]    add_sum;
    res_t               res_d;
    res_t               res_q [LAT];
    logic [LAT-1:0]     vld_q;
    logic               adv;

    assign op       = op_e'(in_op);
    assign mode     = mode_e'(in_mode);
    assign addsub   = (op == OP_ADD) || (op == OP_SUB);
    assign sub_en   = (op == OP_SUB) || (op == OP_SLT);
    assign lane_cut = NLANE16'(lane_cut_mask(mode));
    // MUL is always per element, so every element is its own lane for flag purposes.
    assign cut      = (op == OP_MUL) ? '1 : lane_cut;
    assign lsb      = {cut[NLANE16-2:0], 1'b1};

    simd_lane_adder #(
        .VLEN(VLEN)
    ) u_lane_adder (
        .a_i   (in_a),
        .b_i   (in_b),
        .cut_i (lane_cut),
        .sub_i (sub_en),
        .sum_o (add_sum),
        .cout_o(add_cout),
        .ovf_o (add_ovf)
    );

`ifdef SIMD_ALU_SAT_EN
    logic [NLANE16-1:0] lane_sat;
    logic [NLANE16-1:0] lane_sneg;

    always_comb begin
        logic ovf_run;
        logic sgn_run;
        ovf_run   = 1'b0;
        sgn_run   = 1'b0;
        lane_sat  = '0;
        lane_sneg = '0;
        for (int e = NLANE16 - 1; e >= 0; e--) begin
            if (cut[e]) begin
                ovf_run = add_ovf[e] && in_sat && addsub;
                sgn_run = in_a[e*ELEM_W + ELEM_W - 1];
            end
            lane_sat[e]  = ovf_run;
            lane_sneg[e] = sgn_run;
        end
    end
`else
    logic sat_unused;
    assign sat_unused = in_sat;
`endif

    always_comb begin
        logic                lt_run;
        logic                zero_run;
        logic [ELEM_W-1:0]   ea;
        logic [ELEM_W-1:0]   eb;
        logic [ELEM_W-1:0]   er;
        logic [2*ELEM_W-1:0] prod;
        logic [NLANE16-1:0]  lane_lt;
        logic [NLANE16-1:0]  zero_acc;

        res_d     = '0;
        res_d.tag = in_tag;
        lt_run    = 1'b0;
        zero_run  = 1'b0;
        ea        = '0;
        eb        = '0;
        er        = '0;
        prod      = '0;
        lane_lt   = '0;
        zero_acc  = '0;

        // Signed A<B is decided at the lane's top element (sign of A-B xor overflow), then broadcast down.
        for (int e = NLANE16 - 1; e >= 0; e--) begin
            if (cut[e]) begin
                lt_run = add_sum[e*ELEM_W + ELEM_W - 1] ^ add_ovf[e];
            end
            lane_lt[e] = lt_run;
        end

        for (int e = 0; e < NLANE16; e++) begin
            ea   = in_a[e*ELEM_W +: ELEM_W];
            eb   = in_b[e*ELEM_W +: ELEM_W];
            prod = {{ELEM_W{1'b0}}, ea} * {{ELEM_W{1'b0}}, eb};
            er   = '0;
            case (op)
                OP_ADD, OP_SUB: begin
                    er             = add_sum[e*ELEM_W +: ELEM_W];
                    res_d.carry[e] = add_cout[e] & cut[e];
                    res_d.ovf[e]   = add_ovf[e] & cut[e];
                end
                OP_MUL: begin
                    er             = prod[ELEM_W-1:0];
                    res_d.carry[e] = |prod[2*ELEM_W-1:ELEM_W];
                end
                OP_AND:  er = ea & eb;
                OP_OR:   er = ea | eb;
                OP_XOR:  er = ea ^ eb;
                OP_SLT:  er = {{(ELEM_W-1){1'b0}}, lane_lt[e] & lsb[e]};
                default: res_d.err = 1'b1;
            endcase
`ifdef SIMD_ALU_SAT_EN
            if (lane_sat[e]) begin
                er = cut[e] ? {lane_sneg[e], {(ELEM_W-1){~lane_sneg[e]}}} : {ELEM_W{~lane_sneg[e]}};
            end
`endif
            res_d.dat[e*ELEM_W +: ELEM_W] = er;
            res_d.neg[e] = cut[e] & er[ELEM_W-1];
            zero_run     = (lsb[e] | zero_run) & (er == '0);
            zero_acc[e]  = zero_run;
        end

        zero_run = 1'b0;
        for (int e = NLANE16 - 1; e >= 0; e--) begin
            if (cut[e]) begin
                zero_run = zero_acc[e];
            end
            res_d.zero[e] = zero_run & ~res_d.err;
        end
    end

    assign adv      = !vld_q[LAT-1] || out_ready;
    assign in_ready = adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                res_q[s] <= '0;
            end
        end else if (adv) begin
            vld_q[0] <= in_valid;
            if (in_valid) begin
                res_q[0] <= res_d;
            end
            for (int s = 1; s < LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                res_q[s] <= res_q[s-1];
            end
        end
    end

    assign out_valid = vld_q[LAT-1];
    assign out_data  = res_q[LAT-1].dat;
    assign out_tag   = res_q[LAT-1].tag;
    assign out_carry = res_q[LAT-1].carry;
    assign out_ovf   = res_q[LAT-1].ovf;
    assign out_zero  = res_q[LAT-1].zero;
    assign out_neg   = res_q[LAT-1].neg;
    assign out_err   = res_q[LAT-1].err;

endmodule

// File: tb/tb_simd_alu_pipe.sv
// Scoreboarded bench for simd_alu_pipe: lane-level reference model, directed corner cases, backpressure, reset and random traffic.
module tb_simd_alu_pipe;

    localparam int LAT = 2;

    typedef struct packed {
        logic [255:0] dat;
        logic [3:0]   tag;
        logic [15:0]  car;
        logic [15:0]  ovf;
        logic [15:0]  zer;
        logic [15:0]  neg;
        logic         err;
        logic [31:0]  cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_sat, out_valid, out_ready, out_err;
    logic [2:0]   in_op;
    logic [1:0]   in_mode;
    logic [255:0] in_a, in_b, out_data;
    logic [3:0]   in_tag, out_tag;
    logic [15:0]  out_carry, out_ovf, out_zero, out_neg;

    exp_t         q[$];
    logic [3:0]   bp_tags[$];
    logic         bp_on = 1'b0;
    logic [3:0]   tag_ctr = '0;
    logic [31:0]  cyc = '0;
    int           n_vec = 0, n_err = 0, n_acc = 0, n_out = 0, n_drop = 0, lat_left = 0;
    logic [255:0] last_dat;
    logic [15:0]  last_car, last_ovf, last_zer, last_neg;
    logic         last_err;

    simd_alu_pipe #(.VLEN(256), .LAT(LAT), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_mode(in_mode), .in_sat(in_sat), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero),
        .out_neg(out_neg), .out_err(out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 32'd1;

    task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [1:0] mode, input logic sat,
                                   input logic [255:0] a, input logic [255:0] b);
        exp_t         e;
        int           lw, epl, msb;
        logic [128:0] m, la, lb, s;
        logic [127:0] r;
        logic         sa, sb, sr, cy, ov, lt;
        logic [31:0]  p;
        e = '0;
        if (op == 3'b111) begin
            e.err = 1'b1;
            return e;
        end
        if (op == 3'b010) begin
            for (int i = 0; i < 16; i++) begin
                p = {16'b0, a[i*16 +: 16]} * {16'b0, b[i*16 +: 16]};
                e.dat[i*16 +: 16] = p[15:0];
                e.car[i] = p[31:16] != 16'h0;
                e.zer[i] = p[15:0] == 16'h0;
                e.neg[i] = p[15];
            end
            return e;
        end
        lw  = 16 << mode;
        epl = lw / 16;
        m   = (129'd1 << lw) - 129'd1;
        for (int l = 0; l < 256 / lw; l++) begin
            la = {1'b0, 128'(a >> (l * lw))} & m;
            lb = {1'b0, 128'(b >> (l * lw))} & m;
            sa = la[lw-1];
            sb = lb[lw-1];
            s  = '0;
            case (op)
                3'b000: s = la + lb;
                3'b001: s = la + (~lb & m) + 129'd1;
                3'b011: s = la & lb;
                3'b100: s = la | lb;
                3'b110: s = la ^ lb;
                default: begin
                    lt = (sa != sb) ? sa : (la < lb);
                    s  = {128'b0, lt};
                end
            endcase
            r  = s[127:0] & m[127:0];
            sr = r[lw-1];
            cy = s[lw];
            ov = (op == 3'b000) ? (sa == sb && sr != sa) : (sa != sb && sr != sa);
`ifdef SIMD_ALU_SAT_EN
            if (op <= 3'b001 && sat && ov)
                r = sa ? (128'd1 << (lw - 1)) : ((128'd1 << (lw - 1)) - 128'd1);
`endif
            msb = l * epl + epl - 1;
            e.dat = e.dat | ({128'b0, r} << (l * lw));
            if (op <= 3'b001) begin
                e.car[msb] = cy;
                e.ovf[msb] = ov;
            end
            e.neg[msb] = r[lw-1];
            for (int k = 0; k < epl; k++) e.zer[l*epl + k] = (r == 128'b0);
        end
        return e;
    endfunction

    // Monitor: scoreboard pops on handshake; stalled outputs must hold the head result.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid) begin
            if (q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else if (out_ready) begin
                e = q.pop_front();
                n_out++;
                chk("data", out_data, e.dat);
                chk("tag", out_tag, e.tag);
                chk("flags", {out_carry, out_ovf, out_zero, out_neg, out_err},
                    {e.car, e.ovf, e.zer, e.neg, e.err});
                if (lat_left > 0) begin
                    chk("latency", cyc - e.cyc, LAT);
                    lat_left--;
                end
                if (bp_on) bp_tags.push_back(out_tag);
                last_dat = out_data; last_car = out_carry; last_ovf = out_ovf;
                last_zer = out_zero; last_neg = out_neg;   last_err = out_err;
            end else begin
                chk("stall_in_ready", in_ready, 1'b0);
                chk("stall_hold", out_data, q[0].dat);
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [1:0] mode, input logic sat,
                        input logic [255:0] a, input logic [255:0] b);
        exp_t e;
        int   guard;
        e = model(op, mode, sat, a, b);
        e.tag = tag_ctr;
        in_valid = 1'b1; in_op = op; in_mode = mode; in_sat = sat;
        in_a = a; in_b = b; in_tag = tag_ctr;
        guard = 0;
        forever begin
            @(negedge clk);
            if (in_ready || guard > 100) break;
            guard++;
        end
        if (in_ready) begin
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
            tag_ctr = tag_ctr + 4'd1;
        end else begin
            chk("accept_timeout", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 && guard < 200) begin
            @(posedge clk);
            guard++;
        end
        chk("drain", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic one(input logic [2:0] op, input logic [1:0] mode, input logic sat,
                       input logic [255:0] a, input logic [255:0] b);
        lat_left = 1;
        send(op, mode, sat, a, b);
        drain();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [255:0] ra, rb;
        logic         rnd_done;
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_mode = '0; in_sat = 1'b0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        #3;
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_data", out_data, 256'h0);
        chk("rst_side", {out_tag, out_carry, out_ovf, out_zero, out_neg, out_err}, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_ready", in_ready, 1'b1);

        one(3'b000, 2'b00, 1'b0, 256'h0000_FFFF, 256'h1);
        chk("add16_lo", last_dat[31:0], 32'h0000_0000);
        chk("add16_c0z0", {last_car[0], last_zer[0]}, 2'b11);
        one(3'b000, 2'b01, 1'b0, 256'h0000_FFFF, 256'h1);
        chk("add32_lo", last_dat[31:0], 32'h0001_0000);
        chk("add32_carry", last_car[1:0], 2'b00);
        one(3'b001, 2'b10, 1'b0, 256'h0, 256'h1);
        chk("sub64_res", last_dat[63:0], 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sub64_flags", {last_neg[3], last_car[3], last_ovf[3]}, 3'b100);
        one(3'b001, 2'b10, 1'b1, 256'h8000_0000_0000_0000, 256'h1);
        chk("sub64_ovf", last_ovf[3], 1'b1);
`ifdef SIMD_ALU_SAT_EN
        chk("sub64_sat", last_dat[63:0], 64'h8000_0000_0000_0000);
`else
        chk("sub64_wrap", last_dat[63:0], 64'h7FFF_FFFF_FFFF_FFFF);
`endif
        one(3'b010, 2'b11, 1'b0, 256'h0100, 256'h0100);
        chk("mul_hi_lost", {last_dat[15:0], last_car[0], last_zer[0]}, {16'h0000, 2'b11});
        one(3'b010, 2'b00, 1'b0, 256'h3, 256'h5);
        chk("mul_3x5", last_dat[15:0], 16'h000F);
        one(3'b000, 2'b11, 1'b0, {128'h5, {128{1'b1}}}, {128'h0, 128'h1});
        chk("add128_res", last_dat, {128'h5, 128'h0});
        chk("add128_flags", {last_car[15], last_car[7], last_zer}, {2'b01, 16'h00FF});
        one(3'b101, 2'b01, 1'b0, 256'hFFFF_FFFF, 256'h0);
        chk("slt32", last_dat[31:0], 32'h1);
        one(3'b110, 2'b00, 1'b0, 256'h8F0F, 256'h0F0F);
        chk("xor16", {last_dat[15:0], last_neg[0]}, {16'h8000, 1'b1});
        one(3'b111, 2'b00, 1'b0, {256{1'b1}}, 256'h1);
        chk("rsv_data_err", {last_dat, last_err}, {256'h0, 1'b1});

        // Back-to-back with a three-cycle output stall in the middle.
        tag_ctr = '0;
        bp_on = 1'b1;
        lat_left = 1;
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    ra = {8{$urandom}};
                    rb = {8{$urandom}};
                    send(3'(i % 5), 2'(i % 4), 1'b0, ra, rb);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        bp_on = 1'b0;
        chk("bp_count", bp_tags.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < bp_tags.size()) chk("bp_tag_order", bp_tags[i], i);
        end

        // Random traffic with random output backpressure.
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int k = 0; k < 8; k++) begin
                        ra[k*32 +: 32] = $urandom;
                        rb[k*32 +: 32] = $urandom;
                    end
                    if (i % 5 == 0) rb = ra;
                    send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ra, rb);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset while two operations are in flight.
        send(3'b000, 2'b00, 1'b0, 256'h11, 256'h22);
        send(3'b001, 2'b01, 1'b0, 256'h33, 256'h44);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_flight_valid", out_valid, 1'b0);
        chk("rst_flight_data", out_data, 256'h0);
        n_drop += q.size();
        q.delete();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_quiet", out_valid, 1'b0);
        chk("no_loss", n_out, n_acc - n_drop);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
